ws2812_frame_driver: RTL and testbench

Frame-level sequencer that drives a WS2812 daisy chain (a string of `led` cells) from a single serial output. It pulls one 24-bit pixel per LED from an upstream valid/ready stream and serializes each pixel MSB-first with nominal T0H/T1H/bit-period timing. Between pixels it inserts no gap when data is ready. After the last pixel it holds the line low for the reset/latch time (RET) so the chain latches. It is the block that owns the chain's `i_serial` input.

---
 rtl/ws2812_frame_driver.sv | 239 +++++++++++++++++++++++
 tb/tb_ws2812_frame_driver.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver: pulls one 24-bit GRB pixel per LED from a valid/ready
// stream and serializes the frame onto a WS2812 chain. Each bit is one
// T_BIT-cycle period: high for T0H or T1H cycles, then low. After the last
// pixel the line stays low for T_RET cycles so the chain latches. A one-deep
// prefetch register keeps pixel boundaries seamless while upstream keeps up.
// If upstream stalls longer than UF_LIM cycles, the frame is aborted.
module ws2812_frame_driver #(
    parameter int N_LEDS = 2,
    parameter int T0H    = 20,
    parameter int T1H    = 40,
    parameter int T_BIT  = 63,
    parameter int T_RET  = 2600,
    parameter int UF_LIM = 1300
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_px_valid,
    input  logic [23:0] i_px_data,
    output logic        o_px_ready,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underflow
);

    // The phase counter also times the bit period, so size it for the larger of the two.
    localparam int PH_MAX = (T_RET > T_BIT) ? T_RET : T_BIT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PX_W   = $clog2(N_LEDS + 1);

    localparam logic [PH_W-1:0] PH_T0H_END = PH_W'(T0H - 1);
    localparam logic [PH_W-1:0] PH_T1H_END = PH_W'(T1H - 1);
    localparam logic [PH_W-1:0] PH_BIT_END = PH_W'(T_BIT - 1);
    localparam logic [PH_W-1:0] PH_RET_END = PH_W'(T_RET - 1);
    localparam logic [PH_W-1:0] PH_DONE    = PH_W'(T_RET);
    localparam logic [PH_W-1:0] PH_UF_END  = PH_W'(UF_LIM - 1);
    localparam logic [PX_W-1:0] PX_N       = PX_W'(N_LEDS);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FETCH,
        S_HIGH,
        S_LOW,
        S_STALL,
        S_LATCH
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [PH_W-1:0]   ph_cnt;
    logic [PH_W-1:0]   ph_n;
    logic [4:0]        bit_cnt;
    logic [4:0]        bit_n;
    logic [PX_W-1:0]   px_sent;
    logic [PX_W-1:0]   sent_n;
    logic [PX_W-1:0]   px_fetched;
    logic [23:0]       sr;
    logic [23:0]       hold;
    logic              hold_v;
    logic              load_sr;
    logic              shift_sr;
    logic              set_uf;
    logic              frame_clr;
    logic              serial_n;
    logic              done_n;
    logic              px_ready;
    logic              accept;
    logic [PH_W-1:0]   hi_end;

    // Upstream may fill the prefetch slot whenever a frame is active and pixels remain.
    always_comb begin
        px_ready = 1'b0;
        if ((state == S_FETCH) || (state == S_HIGH) ||
            (state == S_LOW) || (state == S_STALL)) begin
            px_ready = !hold_v && (px_fetched < PX_N);
        end
    end

    assign accept      = px_ready && i_px_valid;
    assign o_px_ready  = px_ready;
    assign o_busy      = (state != S_IDLE);
    assign hi_end      = sr[23] ? PH_T1H_END : PH_T0H_END;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, counter updates and datapath strobes for the frame sequence.
    always_comb begin
        state_n   = state;
        ph_n      = ph_cnt;
        bit_n     = bit_cnt;
        sent_n    = px_sent;
        load_sr   = 1'b0;
        shift_sr  = 1'b0;
        set_uf    = 1'b0;
        frame_clr = 1'b0;
        case (state)
            S_INIT: begin
                if (ph_cnt == PH_RET_END) begin
                    ph_n    = '0;
                    state_n = S_IDLE;
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (i_start) begin
                    frame_clr = 1'b1;
                    ph_n      = '0;
                    bit_n     = '0;
                    sent_n    = '0;
                    state_n   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (hold_v) begin
                    load_sr = 1'b1;
                    bit_n   = '0;
                    ph_n    = '0;
                    state_n = S_HIGH;
                end
            end
            S_HIGH: begin
                ph_n = ph_cnt + 1'b1;
                if (ph_cnt == hi_end) begin
                    state_n = S_LOW;
                end
            end
            S_LOW: begin
                if (ph_cnt == PH_BIT_END) begin
                    ph_n = '0;
                    if (bit_cnt != 5'd23) begin
                        shift_sr = 1'b1;
                        bit_n    = bit_cnt + 5'd1;
                        state_n  = S_HIGH;
                    end else begin
                        sent_n = px_sent + 1'b1;
                        bit_n  = '0;
                        if ((px_sent + 1'b1) == PX_N) begin
                            state_n = S_LATCH;
                        end else if (hold_v) begin
                            load_sr = 1'b1;
                            state_n = S_HIGH;
                        end else begin
                            state_n = S_STALL;
                        end
                    end
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            S_STALL: begin
                if (hold_v) begin
                    load_sr = 1'b1;
                    ph_n    = '0;
                    state_n = S_HIGH;
                end else if (ph_cnt == PH_UF_END) begin
                    set_uf  = 1'b1;
                    ph_n    = '0;
                    state_n = S_LATCH;
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                if (ph_cnt == PH_DONE) begin
                    ph_n    = '0;
                    state_n = S_IDLE;
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    // The line is registered and follows the state being entered, so it is high exactly in HIGH.
    assign serial_n = (state_n == S_HIGH);
    // Done fires on the cycle after the last of the T_RET low cycles.
    assign done_n   = (state == S_LATCH) && (ph_cnt == PH_RET_END);

    // Control counters, prefetch flag and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ph_cnt      <= '0;
            bit_cnt     <= '0;
            px_sent     <= '0;
            px_fetched  <= '0;
            hold_v      <= 1'b0;
            o_serial    <= 1'b0;
            o_done      <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            ph_cnt   <= ph_n;
            bit_cnt  <= bit_n;
            px_sent  <= sent_n;
            o_serial <= serial_n;
            o_done   <= done_n;
            if (frame_clr) begin
                px_fetched  <= '0;
                hold_v      <= 1'b0;
                o_underflow <= 1'b0;
            end else begin
                if (accept) begin
                    px_fetched <= px_fetched + 1'b1;
                    hold_v     <= 1'b1;
                end else if (load_sr) begin
                    hold_v <= 1'b0;
                end
                if (set_uf) begin
                    o_underflow <= 1'b1;
                end
            end
        end
    end

    // Pixel data path: prefetch capture and MSB-first shift register (data needs no reset).
    always_ff @(posedge i_clk) begin
        if (accept) begin
            hold <= i_px_data;
        end
        if (load_sr) begin
            sr <= hold;
        end else if (shift_sr) begin
            sr <= {sr[22:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Testbench for ws2812_frame_driver: table of frame scenarios plus hand-written
// reset sequences; a line decoder feeds decoded pixels to a scoreboard.
module tb_ws2812_frame_driver;

    localparam int N_LEDS = 2;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int T_BIT  = 6;
    localparam int T_RET  = 10;
    localparam int UF_LIM = 5;
    // Start sampled at edge 0: handshake at edge 1, HIGH from edge 2, first pixel ends 24 bits later.
    localparam int PX_END = 2 + 24 * T_BIT;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_px_valid;
    logic [23:0] i_px_data;
    logic        o_px_ready;
    logic        o_serial;
    logic        o_busy;
    logic        o_done;
    logic        o_underflow;

    int checks = 0;
    int errors = 0;

    logic [23:0] sb[$];
    logic [23:0] led[2];
    int          led_cnt = 0;
    logic        exp_uf_prev = 1'b0;

    // d1: -1 second pixel valid immediately, -2 withheld until after abort, >=0 cycles after pixel 0 ends.
    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        int          d1;
        int          mid_start;
        logic        exp_uf;
        int          exp_extra;
    } vec_t;

    vec_t vecs[7];

    ws2812_frame_driver #(
        .N_LEDS(N_LEDS),
        .T0H   (T0H),
        .T1H   (T1H),
        .T_BIT (T_BIT),
        .T_RET (T_RET),
        .UF_LIM(UF_LIM)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_px_valid (i_px_valid),
        .i_px_data  (i_px_data),
        .o_px_ready (o_px_ready),
        .o_serial   (o_serial),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_underflow(o_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Line decoder: high width gives the bit, every 24 bits are one pixel for the next LED.
    initial begin : line_monitor
        logic        m_prev;
        int          m_hi;
        int          m_nb;
        logic [23:0] m_word;
        logic [23:0] m_exp;
        m_prev = 1'b0;
        m_hi   = 0;
        m_nb   = 0;
        m_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_prev = 1'b0;
                m_hi   = 0;
                m_nb   = 0;
                m_word = '0;
            end else begin
                if (o_serial) begin
                    m_hi++;
                end else if (m_prev) begin
                    checks++;
                    if (m_hi != T0H && m_hi != T1H) begin
                        errors++;
                        $display("FAIL high_width: got %0d cycles, want %0d or %0d", m_hi, T0H, T1H);
                    end
                    m_word = {m_word[22:0], (m_hi == T1H)};
                    m_nb++;
                    m_hi = 0;
                    if (m_nb == 24) begin
                        m_nb = 0;
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL pixel_unexpected: got 0x%06h, want no pixel", m_word);
                        end else begin
                            m_exp = sb.pop_front();
                            if (m_word != m_exp) begin
                                errors++;
                                $display("FAIL pixel_data: got 0x%06h, want 0x%06h", m_word, m_exp);
                            end
                        end
                        if (led_cnt < 2) led[led_cnt] = m_word;
                        led_cnt++;
                    end
                end
                m_prev = o_serial;
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int          n;
        int          rel1;
        int          idx;
        int          pushes;
        int          done_at;
        int          exp_done;
        int          bad;
        int          want;
        int          npix;
        bit          pend;
        logic        prev_s;
        int          rises[$];
        logic [23:0] pix[2];
        pix[0] = v.p0;
        pix[1] = v.p1;
        if (v.d1 == -1)      rel1 = 0;
        else if (v.d1 == -2) rel1 = PX_END + UF_LIM + 2;
        else                 rel1 = PX_END + v.d1;
        npix     = v.exp_uf ? 1 : 2;
        exp_done = v.exp_uf ? (PX_END + UF_LIM + T_RET)
                            : (PX_END + v.exp_extra + 24 * T_BIT + T_RET);

        @(negedge clk);
        chk("uf_sticky_idle", int'(o_underflow), int'(exp_uf_prev));
        sb.delete();
        led_cnt = 0;
        i_start = 1'b1;
        @(posedge clk);
        n       = -1;
        idx     = 0;
        pushes  = 0;
        pend    = 1'b0;
        prev_s  = 1'b0;
        done_at = -1;
        while (done_at < 0 && n < 600) begin
            @(negedge clk);
            n++;
            i_start = (n == v.mid_start);
            if (n == 0) chk("uf_cleared_by_start", int'(o_underflow), 0);
            if (o_serial && !prev_s) rises.push_back(n);
            prev_s = o_serial;
            if (o_done) done_at = n;
            if (pend) begin
                idx++;
                pend       = 1'b0;
                i_px_valid = 1'b0;
            end
            if (idx < 2 && !i_px_valid && n >= ((idx == 0) ? 0 : rel1)) begin
                i_px_valid = 1'b1;
                i_px_data  = pix[idx];
            end
            if (i_px_valid && o_px_ready) begin
                sb.push_back(i_px_data);
                pushes++;
                pend = 1'b1;
            end
        end
        i_start = 1'b0;
        if (done_at < 0) begin
            chk("done_timeout", n, -1);
        end else begin
            chk("done_cycle", done_at, exp_done);
        end
        @(negedge clk);
        chk("busy_after_done", int'(o_busy), 0);
        chk("done_width", int'(o_done), 0);
        chk("ready_after_frame", int'(o_px_ready), 0);
        i_px_valid = 1'b0;
        chk("underflow", int'(o_underflow), int'(v.exp_uf));
        chk("handshakes", pushes, npix);
        chk("sb_empty", sb.size(), 0);
        chk("rise_count", rises.size(), 24 * npix);
        if (rises.size() > 0) chk("first_rise", rises[0], 2);
        bad = 0;
        for (int i = 1; i < rises.size(); i++) begin
            want = T_BIT + ((i == 24) ? v.exp_extra : 0);
            if (rises[i] - rises[i-1] != want) bad++;
        end
        chk("bit_periods", bad, 0);
        chk("led_count", led_cnt, npix);
        chk("led0", int'(led[0]), int'(v.p0));
        if (!v.exp_uf) chk("led1", int'(led[1]), int'(v.p1));
        exp_uf_prev = v.exp_uf;
    endtask

    initial begin : main
        int cnt;
        int bad;
        int t;
        vecs[0] = '{24'hFF00FF, 24'h00FF00, -1, -1, 1'b0, 0};
        vecs[1] = '{24'hA5C30F, 24'h5A3CF0,  1, -1, 1'b0, 3};
        vecs[2] = '{24'h123456, 24'hFEDCBA, -1, 50, 1'b0, 0};
        vecs[3] = '{24'h800001, 24'h7FFFFE,  0, -1, 1'b0, 2};
        vecs[4] = '{24'hC0FFEE, 24'hABCDEF,  3, -1, 1'b0, 5};
        vecs[5] = '{24'hF0F0F0, 24'h0F0F0F, -2, -1, 1'b1, 0};
        vecs[6] = '{24'h000000, 24'hFFFFFF, -1, -1, 1'b0, 0};

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_px_valid = 1'b0;
        i_px_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_serial", int'(o_serial), 0);
        chk("reset_busy", int'(o_busy), 1);
        chk("reset_done", int'(o_done), 0);
        chk("reset_ready", int'(o_px_ready), 0);
        chk("reset_underflow", int'(o_underflow), 0);

        // INIT: a start pulse here must be ignored.
        rst_n = 1'b1;
        cnt   = 0;
        bad   = 0;
        while (o_busy && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            if (o_serial || o_done) bad++;
            i_start = (cnt == 3);
        end
        i_start = 1'b0;
        chk("init_length", cnt, T_RET);
        chk("init_quiet", bad, 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_busy || o_serial || o_done) bad++;
        end
        chk("idle_after_init", bad, 0);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Reset asserted in the middle of a HIGH phase.
        @(negedge clk);
        i_start    = 1'b1;
        i_px_valid = 1'b1;
        i_px_data  = 24'hFFFFFF;
        @(negedge clk);
        i_start = 1'b0;
        t = 0;
        while (!o_serial && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("serial_rise_wait", int'(o_serial), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_serial_low", int'(o_serial), 0);
        chk("rst_busy", int'(o_busy), 1);
        chk("rst_ready", int'(o_px_ready), 0);
        chk("rst_done", int'(o_done), 0);
        i_px_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
        bad   = 0;
        while (o_busy && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            if (o_serial || o_done) bad++;
        end
        chk("init_length_2", cnt, T_RET);
        chk("init_quiet_2", bad, 0);
        chk("idle_ready", int'(o_px_ready), 0);
        chk("idle_underflow", int'(o_underflow), 0);
        exp_uf_prev = 1'b0;
        run_frame(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
